// File: rtl/phase_round_ctrl_pkg.sv
// Shared types and phase-bus constants for the six-phase round controller.
package phase_round_ctrl_pkg;

    localparam int PHASE_W = 6;

    localparam logic [PHASE_W-1:0] PHASE0 = 6'b100000;
    localparam logic [PHASE_W-1:0] PHASE5 = 6'b000001;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/phase_onehot_chk.sv
// Combinational phase-bus integrity check: one-hot validity and phase-0 compare.
// Only compiled and used when PHASE_CHECK_EN is defined.
`ifdef PHASE_CHECK_EN
module phase_onehot_chk
    import phase_round_ctrl_pkg::*;
(
    input  logic [PHASE_W-1:0] phase,
    output logic               onehot_ok,
    output logic               at_phase0
);

    assign onehot_ok = ($countones(phase) == 1);
    assign at_phase0 = (phase == PHASE0);

endmodule
`endif

// File: rtl/phase_round_ctrl.sv
// Runs a requested number of six-phase rounds on the timing generator, then pulses done.
// Optional phase-integrity checking is enabled with the PHASE_CHECK_EN macro.
//
//   state | meaning
//   IDLE  | generator parked at phase 0, waiting for start
//   RUN   | generator counting (unless hold), rounds counted at phase-5 wrap
//   DONE  | one-cycle done pulse, then back to IDLE
module phase_round_ctrl
    import phase_round_ctrl_pkg::*;
#(
    parameter int RW = 4
) (
    input  logic               clk,
    input  logic               rstb,
    input  logic               start,
    input  logic [RW-1:0]      rounds,
    input  logic               hold,
    input  logic [PHASE_W-1:0] phase_in,
    output logic               cnt_en,
    output logic               busy,
    output logic               done,
    output logic [RW-1:0]      round_cnt,
    output logic               phase_err
);

    state_t        state;
    logic [RW-1:0] remaining;
    logic          start_ok;
    logic          round_end;

    assign cnt_en    = (state == RUN) && !hold;
    assign busy      = (state != IDLE);
    // The generator wraps to phase 0 on the same edge that completes a round.
    assign round_end = cnt_en && (phase_in == PHASE5);

`ifdef PHASE_CHECK_EN
    logic onehot_ok;
    logic at_phase0;
    logic err_set;

    phase_onehot_chk u_chk (
        .phase     (phase_in),
        .onehot_ok (onehot_ok),
        .at_phase0 (at_phase0)
    );

    assign start_ok = at_phase0;
    assign err_set  = !onehot_ok || ((state == IDLE) && start && !at_phase0);

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            phase_err <= 1'b0;
        end else if (err_set) begin
            phase_err <= 1'b1;
        end
    end
`else
    assign start_ok  = 1'b1;
    assign phase_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state     <= IDLE;
            remaining <= '0;
            round_cnt <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && start_ok) begin
                        round_cnt <= '0;
                        if (rounds == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            remaining <= rounds;
                            state     <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (round_end) begin
                        round_cnt <= round_cnt + 1'b1;
                        remaining <= remaining - 1'b1;
                        if (remaining == RW'(1)) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_phase_round_ctrl.sv
// Self-checking bench for phase_round_ctrl with an attached six-phase generator model.
module tb_phase_round_ctrl;
    import phase_round_ctrl_pkg::*;

    localparam int RW = 4;

    logic          clk = 1'b0;
    logic          rstb;
    logic          start;
    logic [RW-1:0] rounds;
    logic          hold;
    logic [5:0]    phase_in;
    logic          cnt_en;
    logic          busy;
    logic          done;
    logic [RW-1:0] round_cnt;
    logic          phase_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    phase_round_ctrl #(.RW(RW)) dut (
        .clk       (clk),
        .rstb      (rstb),
        .start     (start),
        .rounds    (rounds),
        .hold      (hold),
        .phase_in  (phase_in),
        .cnt_en    (cnt_en),
        .busy      (busy),
        .done      (done),
        .round_cnt (round_cnt),
        .phase_err (phase_err)
    );

    // Attached timing generator: mod-6 counter, one-hot decode, shares rstb.
    int         gen_ph;
    logic       ovr_en;
    logic [5:0] ovr_val;

    always @(posedge clk or negedge rstb) begin
        if (!rstb)       gen_ph <= 0;
        else if (cnt_en) gen_ph <= (gen_ph == 5) ? 0 : gen_ph + 1;
    end

    assign phase_in = ovr_en ? ovr_val : (PHASE0 >> gen_ph);

    // Reference model: a run is 6*R enabled edges; rounds completed = edges/6.
    bit m_active, m_done, m_err;
    int m_edges, m_target, m_rcnt;

    logic          s_en, s_busy, s_done;
    logic [RW-1:0] s_rc;

    typedef struct {
        bit s; int r; bit h;
        bit en; bit bz; bit dn; int rc;
    } vec_t;
    vec_t tbl[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_active = 0; m_done = 0; m_err = 0;
        m_edges = 0; m_target = 0; m_rcnt = 0;
    endtask

    // Called at posedge+#1: drive inputs, check at negedge, advance model at next edge.
    task automatic step(input bit s, input int r, input bit h);
        logic [5:0] p;
        bit ok, err_now, idle;
        start = s; rounds = r[RW-1:0]; hold = h;
        @(negedge clk);
        p = phase_in;
        idle = !m_active && !m_done;
        s_en = cnt_en; s_busy = busy; s_done = done; s_rc = round_cnt;
        chk("cnt_en",    cnt_en,    m_active && !h);
        chk("busy",      busy,      m_active || m_done);
        chk("done",      done,      m_done);
        chk("round_cnt", round_cnt, m_rcnt);
        chk("phase_err", phase_err, m_err);
        if (idle && !ovr_en) chk("idle_phase0", phase_in, PHASE0);
        ok = 1; err_now = 0;
`ifdef PHASE_CHECK_EN
        if ($countones(p) != 1) err_now = 1;
        ok = (p == PHASE0);
        if (idle && s && !ok) err_now = 1;
`endif
        @(posedge clk); #1;
        if (err_now) m_err = 1;
        if (m_done) begin
            m_done = 0;
        end else if (m_active) begin
            if (!h) begin
                m_edges++;
                m_rcnt = (m_edges / 6) % (1 << RW);
                if (m_edges == m_target) begin m_active = 0; m_done = 1; end
            end
        end else if (s && ok) begin
            m_rcnt = 0;
            if (r == 0) m_done = 1;
            else begin m_active = 1; m_edges = 0; m_target = 6 * r; end
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        start = 0; hold = 0; rounds = '0; ovr_en = 0; ovr_val = PHASE0;
        rstb = 1'b0;
        #2;
        chk("rst_cnt_en", cnt_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_round_cnt", round_cnt, 0);
        chk("rst_phase_err", phase_err, 0);
        model_reset();
        @(posedge clk); #1;
        rstb = 1'b1;
    endtask

    initial begin
        int n_en, done_at;
        rstb = 1'b0; start = 0; hold = 0; rounds = '0; ovr_en = 0; ovr_val = PHASE0;
        model_reset();

        // Reset and quiet idle
        do_reset();
        for (int i = 0; i < 3; i++) step(0, 0, 0);

        // Directed table: rounds=0 run, then rounds=1 with a 3-cycle hold at phase 5
        tbl[0]  = '{0, 0, 0, 0, 0, 0, 0};
        tbl[1]  = '{1, 0, 0, 0, 0, 0, 0};
        tbl[2]  = '{0, 0, 0, 0, 1, 1, 0};
        tbl[3]  = '{0, 0, 0, 0, 0, 0, 0};
        tbl[4]  = '{1, 1, 0, 0, 0, 0, 0};
        tbl[5]  = '{0, 0, 0, 1, 1, 0, 0};
        tbl[6]  = '{1, 2, 0, 1, 1, 0, 0};
        tbl[7]  = '{0, 0, 0, 1, 1, 0, 0};
        tbl[8]  = '{0, 0, 0, 1, 1, 0, 0};
        tbl[9]  = '{0, 0, 0, 1, 1, 0, 0};
        tbl[10] = '{0, 0, 1, 0, 1, 0, 0};
        tbl[11] = '{0, 0, 1, 0, 1, 0, 0};
        tbl[12] = '{0, 0, 1, 0, 1, 0, 0};
        tbl[13] = '{0, 0, 0, 1, 1, 0, 0};
        tbl[14] = '{1, 3, 0, 0, 1, 1, 1};
        tbl[15] = '{0, 0, 0, 0, 0, 0, 1};
        for (int i = 0; i < 16; i++) begin
            step(tbl[i].s, tbl[i].r, tbl[i].h);
            chk($sformatf("tbl%0d_cnt_en", i), s_en, tbl[i].en);
            chk($sformatf("tbl%0d_busy", i), s_busy, tbl[i].bz);
            chk($sformatf("tbl%0d_done", i), s_done, tbl[i].dn);
            chk($sformatf("tbl%0d_round_cnt", i), s_rc, tbl[i].rc);
        end

        // Two rounds: cnt_en for 12 cycles, done on cycle 13
        step(1, 2, 0);
        n_en = 0; done_at = -1;
        for (int i = 1; i <= 40; i++) begin
            step(0, 0, 0);
            if (s_en) n_en++;
            if (s_done) begin
                done_at = i;
                chk("t2_round_cnt", s_rc, 2);
                break;
            end
        end
        chk("t2_en_cycles", n_en, 12);
        chk("t2_done_cycle", done_at, 13);
        step(0, 0, 0);
        chk("t2_phase0", phase_in, PHASE0);

        // Start re-pulse during RUN ignored; async reset at phase 3
        step(1, 3, 0);
        step(0, 0, 0);
        step(1, 5, 0);
        step(0, 0, 0);
        chk("t5_phase3", phase_in, PHASE0 >> 3);
        #2;
        rstb = 1'b0;
        #1;
        chk("t5_cnt_en", cnt_en, 0);
        chk("t5_busy", busy, 0);
        chk("t5_round_cnt", round_cnt, 0);
        chk("t5_phase", phase_in, PHASE0);
        model_reset();
        @(posedge clk); #1;
        rstb = 1'b1;
        step(0, 0, 0);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            int r;
            r = ($urandom % 8 == 0) ? 15 : int'($urandom % 4);
            step(($urandom % 4) == 0, r, ($urandom % 5) == 0);
        end
        for (int i = 0; i < 200 && (m_active || m_done); i++) step(0, 0, 0);

`ifdef PHASE_CHECK_EN
        // Corrupted phase sets sticky error; start away from phase 0 is rejected
        do_reset();
        ovr_en = 1; ovr_val = 6'b000011;
        step(0, 0, 0);
        ovr_val = PHASE0;
        step(0, 0, 0);
        chk("t6_err_set", phase_err, 1);
        ovr_val = 6'b010000;
        step(1, 2, 0);
        step(0, 0, 0);
        chk("t6_busy", s_busy, 0);
        chk("t6_err_sticky", phase_err, 1);
        ovr_en = 0;
        step(0, 0, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
